// File: rtl/me_pkg.sv
// =============================================================================
// Module  : me_pkg
// Brief   : Shared memory-op encodings, FSM states and op predicates for me_stage.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package me_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] acc_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/me_load_align.sv
// =============================================================================
// Module  : me_load_align
// Brief   : Selects the loaded byte/half lane and sign- or zero-extends it.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module me_load_align
    import me_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    // Halves use only offset bit 1 and words ignore the offset entirely.
    always_comb begin
        w_byte = i_rdata[8*i_off +: 8];
        w_half = i_rdata[16*i_off[1] +: 16];
        w_sext = (i_op == OP_LB) || (i_op == OP_LH);
        case (acc_size(i_op))
            SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/me_stage.sv
// =============================================================================
// Module  : me_stage
// Brief   : Memory-access stage: loads/stores over req/ready + rvalid bus, WB reg.
//           Define ME_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module me_stage
    import me_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic          rd_we_i,
    input  logic [4:0]    rd_addr_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic [3:0]    mem_op_i,
    input  logic [DW-1:0] st_data_i,
    output logic          stall_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    output logic [3:0]    dmem_be_o,
    input  logic          dmem_ready_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i,
    output logic          wb_valid_o,
    output logic          wb_rd_we_o,
    output logic [4:0]    wb_rd_addr_o,
    output logic [DW-1:0] wb_rd_data_o,
    output logic          misalign_o
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [3:0]    r_op;
    logic [1:0]    r_off;
    logic [4:0]    r_rd_addr;
    logic          r_rd_we;

    logic          r_dmem_req;
    logic          r_dmem_we;
    logic [AW-1:0] r_dmem_addr;
    logic [DW-1:0] r_dmem_wdata;
    logic [3:0]    r_dmem_be;

    logic          r_wb_valid;
    logic          r_wb_rd_we;
    logic [4:0]    r_wb_rd_addr;
    logic [DW-1:0] r_wb_rd_data;
    logic          r_misalign;

    logic          w_is_mem;
    logic          w_misalign;
    logic          w_accept;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_load_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_REQ;
            ST_REQ:  if (dmem_ready_i)  w_state_nxt = is_store(r_op) ? ST_IDLE : ST_RESP;
            ST_RESP: if (dmem_rvalid_i) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / decode logic
    always_comb begin
        w_is_mem = is_load(mem_op_i) || is_store(mem_op_i);
        w_off    = rd_data_i[1:0];
`ifdef ME_MISALIGN_CHECK_EN
        w_misalign = in_valid_i && w_is_mem &&
                     (((acc_size(mem_op_i) == SZ_HALF) && w_off[0]) ||
                      ((acc_size(mem_op_i) == SZ_WORD) && (w_off != 2'b00)));
`else
        w_misalign = 1'b0;
`endif
        w_accept = (r_state == ST_IDLE) && in_valid_i && w_is_mem && !w_misalign;
        stall_o  = (r_state != ST_IDLE) || (in_valid_i && w_is_mem);
        case (acc_size(mem_op_i))
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{st_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = st_data_i;
            end
        endcase
    end

    me_load_align u_load_align (
        .i_op    (r_op),
        .i_off   (r_off),
        .i_rdata (dmem_rdata_i),
        .o_data  (w_load_data)
    );

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_NONE;
            r_off        <= 2'b00;
            r_rd_addr    <= 5'd0;
            r_rd_we      <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= 4'b0000;
            r_wb_valid   <= 1'b0;
            r_wb_rd_we   <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_rd_data <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i && !w_is_mem) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_we   <= rd_we_i && (rd_addr_i != 5'd0);
                        r_wb_rd_addr <= rd_addr_i;
                        r_wb_rd_data <= rd_data_i;
                    end else if (w_misalign) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_we   <= 1'b0;
                        r_wb_rd_addr <= rd_addr_i;
                        r_wb_rd_data <= '0;
                        r_misalign   <= 1'b1;
                    end else if (w_accept) begin
                        r_op         <= mem_op_i;
                        r_off        <= w_off;
                        r_rd_addr    <= rd_addr_i;
                        r_rd_we      <= rd_we_i && (rd_addr_i != 5'd0);
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= is_store(mem_op_i);
                        r_dmem_addr  <= {rd_data_i[AW-1:2], 2'b00};
                        r_dmem_be    <= w_be;
                        r_dmem_wdata <= w_wdata;
                    end
                end
                ST_REQ: begin
                    if (dmem_ready_i) begin
                        r_dmem_req <= 1'b0;
                        if (is_store(r_op)) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_rd_we   <= 1'b0;
                            r_wb_rd_addr <= r_rd_addr;
                            r_wb_rd_data <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_rd_we   <= r_rd_we;
                        r_wb_rd_addr <= r_rd_addr;
                        r_wb_rd_data <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req_o   = r_dmem_req;
    assign dmem_we_o    = r_dmem_we;
    assign dmem_addr_o  = r_dmem_addr;
    assign dmem_wdata_o = r_dmem_wdata;
    assign dmem_be_o    = r_dmem_be;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_we_o   = r_wb_rd_we;
    assign wb_rd_addr_o = r_wb_rd_addr;
    assign wb_rd_data_o = r_wb_rd_data;
    assign misalign_o   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_me_stage.sv
// =============================================================================
// Module  : tb_me_stage
// Brief   : Randomized self-checking bench for me_stage against a behavioural model.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_me_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, rd_we_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i, st_data_i;
    logic [3:0]  mem_op_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_rd_we_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    me_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .rd_we_i(rd_we_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .mem_op_i(mem_op_i),
        .st_data_i(st_data_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_be_o(dmem_be_o), .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_we_o(wb_rd_we_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_data_o(wb_rd_data_o), .misalign_o(misalign_o)
    );

    typedef struct {
        int          lat;
        int          wb_cnt;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        int          req_cnt;
        logic [31:0] req_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        bit          stable;
        bit          stall_ok;
        int          mis_cnt;
        logic        stall_acc;
    } obs_t;

    // ---------------- behavioural reference model ----------------
    function automatic bit m_is_load(int op);  return op >= 1 && op <= 5; endfunction
    function automatic bit m_is_store(int op); return op >= 6 && op <= 8; endfunction
    function automatic int m_bytes(int op);
        if (op == 1 || op == 4 || op == 6) return 1;
        if (op == 2 || op == 5 || op == 7) return 2;
        return 4;
    endfunction
    function automatic bit m_misaligned(int op, longint addr);
`ifdef ME_MISALIGN_CHECK_EN
        if (!(m_is_load(op) || m_is_store(op))) return 0;
        return (addr % m_bytes(op)) != 0;
`else
        return 0;
`endif
    endfunction
    function automatic logic [3:0] m_be(int op, longint addr);
        int n = m_bytes(op);
        longint lane = (n == 4) ? 0 : (addr % 4) / n * n;
        return 4'(((1 << n) - 1) << lane);
    endfunction
    function automatic logic [31:0] m_wdata(int op, longint st);
        int n = m_bytes(op);
        if (n == 1) return 32'((st % 256) * 32'h0101_0101);
        if (n == 2) return 32'((st % 65536) * 32'h0001_0001);
        return 32'(st);
    endfunction
    function automatic logic [31:0] m_load(int op, longint addr, longint rdata);
        int n = m_bytes(op);
        longint lane, v, span;
        if (n == 4) return 32'(rdata);
        lane = (addr % 4) / n * n;
        span = longint'(1) << (8 * n);
        v = (rdata >> (8 * lane)) % span;
        if ((op == 1 || op == 2) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // Drives one instruction and records everything the DUT does with it.
    task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic we,
                          input logic [31:0] addr, input logic [31:0] st,
                          input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                          input bit spur, output obs_t o);
        int resp_cnt = 0;
        int extra = 0;
        bit ready_given = 0;
        bit done = 0;
        o = '{default: 0};
        o.lat = -1; o.stable = 1; o.stall_ok = 1;
        in_valid_i = 1; mem_op_i = op; rd_addr_i = rd; rd_we_i = we;
        rd_data_i = addr; st_data_i = st; dmem_ready_i = spur; dmem_rvalid_i = spur;
        dmem_rdata_i = ~rdata;
        #1 o.stall_acc = stall_o;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            in_valid_i = 0; rd_data_i = $urandom; st_data_i = $urandom; mem_op_i = 4'($urandom);
            dmem_ready_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = $urandom;
            if (wb_valid_o) begin
                o.wb_cnt++;
                if (!done) begin
                    o.lat = cyc; o.wb_we = wb_rd_we_o;
                    o.wb_addr = wb_rd_addr_o; o.wb_data = wb_rd_data_o;
                end
                done = 1;
            end
            if (misalign_o) o.mis_cnt++;
            if (dmem_req_o) begin
                o.req_cnt++;
                if (o.req_cnt == 1) begin
                    o.req_addr = dmem_addr_o; o.be = dmem_be_o; o.wdata = dmem_wdata_o; o.we = dmem_we_o;
                end else if (o.req_addr !== dmem_addr_o || o.be !== dmem_be_o ||
                             o.wdata !== dmem_wdata_o || o.we !== dmem_we_o) begin
                    o.stable = 0;
                end
            end
            if (done == stall_o) o.stall_ok = 0;
            if (done) begin
                extra++;
                if (extra > 1) break;
            end
            if (ready_given && !done) begin
                dmem_rvalid_i = (resp_cnt == rv_dly);
                dmem_rdata_i = dmem_rvalid_i ? rdata : ~rdata;
                resp_cnt++;
            end else if (spur) begin
                dmem_rvalid_i = 1; dmem_rdata_i = ~rdata;
            end
            if (dmem_req_o && o.req_cnt >= rdy_dly) begin
                dmem_ready_i = 1; ready_given = 1;
            end
        end
        dmem_ready_i = 0; dmem_rvalid_i = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid_i = 0; rd_we_i = 0; rd_addr_i = 0; rd_data_i = 0;
        mem_op_i = 0; st_data_i = 0; dmem_ready_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_valid_o,
             wb_rd_we_o, wb_rd_addr_o, wb_rd_data_o, misalign_o} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b wbv=%b wbwe=%b wba=%0d wbd=%h mis=%b, required all 0",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_valid_o,
                     wb_rd_we_o, wb_rd_addr_o, wb_rd_data_o, misalign_o);
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        obs_t o;
        run_op(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 1, 0, 0, o);
        n_cmp++; if (o.lat !== 1) begin n_mis++; $display("FAIL alu_latency: got %0d want 1", o.lat); end
        n_cmp++; if (o.wb_addr !== 5'd5 || o.wb_we !== 1'b1) begin n_mis++; $display("FAIL alu_wb_rd: got addr=%0d we=%b want 5/1", o.wb_addr, o.wb_we); end
        n_cmp++; if (o.wb_data !== 32'h1234) begin n_mis++; $display("FAIL alu_wb_data: got %h want 00001234", o.wb_data); end
        n_cmp++; if (o.stall_acc !== 1'b0 || o.req_cnt !== 0) begin n_mis++; $display("FAIL alu_stall_req: stall=%b req=%0d want 0/0", o.stall_acc, o.req_cnt); end
    endtask

    task automatic test_store_sw();
        obs_t o;
        run_op(4'd8, 5'd9, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 3, 0, 1, o);
        n_cmp++; if (o.req_cnt !== 3 || o.stable !== 1) begin n_mis++; $display("FAIL sw_req_hold: got cycles=%0d stable=%0d want 3/1", o.req_cnt, o.stable); end
        n_cmp++; if (o.req_addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b1) begin n_mis++; $display("FAIL sw_bus: got addr=%h be=%b we=%b want 100/1111/1", o.req_addr, o.be, o.we); end
        n_cmp++; if (o.wdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL sw_wdata: got %h want deadbeef", o.wdata); end
        n_cmp++; if (o.lat !== 4 || o.wb_we !== 1'b0 || o.wb_cnt !== 1) begin n_mis++; $display("FAIL sw_wb: got lat=%0d we=%b pulses=%0d want 4/0/1", o.lat, o.wb_we, o.wb_cnt); end
        n_cmp++; if (o.stall_acc !== 1'b1 || o.stall_ok !== 1) begin n_mis++; $display("FAIL sw_stall: got acc=%b ok=%0d want 1/1", o.stall_acc, o.stall_ok); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_op(4'd1, 5'd7, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1, 2, 0, o);
        n_cmp++; if (o.wb_data !== 32'hFFFF_FF80 || o.lat !== 5) begin n_mis++; $display("FAIL lb_data: got %h lat=%0d want ffffff80/5", o.wb_data, o.lat); end
        n_cmp++; if (o.req_addr !== 32'h100 || o.we !== 1'b0 || o.wb_we !== 1'b1) begin n_mis++; $display("FAIL lb_bus: got addr=%h we=%b wbwe=%b want 100/0/1", o.req_addr, o.we, o.wb_we); end
        run_op(4'd4, 5'd7, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1, 2, 0, o);
        n_cmp++; if (o.wb_data !== 32'h0000_0080) begin n_mis++; $display("FAIL lbu_data: got %h want 00000080", o.wb_data); end
    endtask

    task automatic test_half();
        obs_t o;
        run_op(4'd7, 5'd3, 1'b0, 32'h102, 32'h0000_ABCD, 32'h0, 1, 0, 0, o);
        n_cmp++; if (o.be !== 4'b1100 || o.wdata !== 32'hABCD_ABCD) begin n_mis++; $display("FAIL sh_lane: got be=%b wd=%h want 1100/abcdabcd", o.be, o.wdata); end
        n_cmp++; if (o.lat !== 2) begin n_mis++; $display("FAIL sh_latency: got %0d want 2", o.lat); end
        run_op(4'd2, 5'd4, 1'b1, 32'h102, 32'h0, 32'h7FFF_0000, 1, 0, 0, o);
        n_cmp++; if (o.wb_data !== 32'h0000_7FFF || o.lat !== 3) begin n_mis++; $display("FAIL lh_data: got %h lat=%0d want 00007fff/3", o.wb_data, o.lat); end
    endtask

    task automatic test_rd0();
        obs_t o;
        run_op(4'd3, 5'd0, 1'b1, 32'h200, 32'h0, 32'h1357_9BDF, 2, 1, 0, o);
        n_cmp++; if (o.wb_cnt !== 1 || o.wb_we !== 1'b0) begin n_mis++; $display("FAIL lw_rd0: got pulses=%0d we=%b want 1/0", o.wb_cnt, o.wb_we); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        in_valid_i = 1; mem_op_i = 4'd3; rd_addr_i = 5'd6; rd_we_i = 1; rd_data_i = 32'h40;
        @(posedge clk); #1;
        in_valid_i = 0; dmem_ready_i = 1;
        @(posedge clk); #1;
        dmem_ready_i = 0;
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL rstmid_in_resp: stall got %b want 1", stall_o); end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_valid_o,
             wb_rd_we_o, wb_rd_addr_o, wb_rd_data_o, misalign_o} !== '0) begin
            n_mis++; $display("FAIL rstmid_outputs: req=%b addr=%h wbv=%b stall=%b, required all 0",
                              dmem_req_o, dmem_addr_o, wb_valid_o, stall_o);
        end
        @(posedge clk); #2;
        rst_n = 1;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_valid_o || dmem_req_o || stall_o) pulses++;
        end
        dmem_rvalid_i = 0;
        n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL rstmid_late_rvalid: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_op(4'd3, 5'd8, 1'b1, 32'h101, 32'h0, 32'hA5A5_5A5A, 1, 0, 0, o);
`ifdef ME_MISALIGN_CHECK_EN
        n_cmp++; if (o.mis_cnt !== 1 || o.req_cnt !== 0) begin n_mis++; $display("FAIL misalign_lw: got pulses=%0d req=%0d want 1/0", o.mis_cnt, o.req_cnt); end
        n_cmp++; if (o.lat !== 1 || o.wb_we !== 1'b0) begin n_mis++; $display("FAIL misalign_wb: got lat=%0d we=%b want 1/0", o.lat, o.wb_we); end
`else
        n_cmp++; if (o.mis_cnt !== 0 || o.req_addr !== 32'h100) begin n_mis++; $display("FAIL unaligned_lw: got mis=%0d addr=%h want 0/100", o.mis_cnt, o.req_addr); end
        n_cmp++; if (o.wb_data !== 32'hA5A5_5A5A || o.lat !== 3) begin n_mis++; $display("FAIL unaligned_lw_data: got %h lat=%0d want a5a55a5a/3", o.wb_data, o.lat); end
`endif
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 15);
            logic [4:0] rd = 5'($urandom);
            logic we = 1'($urandom);
            logic [31:0] addr = $urandom;
            logic [31:0] st = $urandom;
            logic [31:0] rdata = $urandom;
            int rdy = $urandom_range(1, 3);
            int rv = $urandom_range(0, 2);
            bit spur = 1'($urandom);
            bit ld = m_is_load(op);
            bit sto = m_is_store(op);
            bit mis = m_misaligned(op, longint'(addr));
            int exp_lat = (!(ld || sto) || mis) ? 1 : (sto ? rdy + 1 : rdy + 2 + rv);
            logic exp_we = (sto || mis) ? 1'b0 : (we && rd != 0);
            run_op(4'(op), rd, we, addr, st, rdata, rdy, rv, spur, o);
            n_cmp++;
            if (o.lat !== exp_lat || o.wb_cnt !== 1 || o.wb_we !== exp_we || o.wb_addr !== rd) begin
                n_mis++; $display("FAIL rnd%0d_wb op=%0d: got lat=%0d pulses=%0d we=%b rd=%0d want %0d/1/%b/%0d",
                                  i, op, o.lat, o.wb_cnt, o.wb_we, o.wb_addr, exp_lat, exp_we, rd);
            end
            n_cmp++;
            if (o.stall_acc !== (ld || sto) || o.stall_ok !== 1 || o.mis_cnt !== int'(mis)) begin
                n_mis++; $display("FAIL rnd%0d_stall op=%0d: got acc=%b ok=%0d mis=%0d want %b/1/%0d",
                                  i, op, o.stall_acc, o.stall_ok, o.mis_cnt, ld || sto, mis);
            end
            if (!(ld || sto)) begin
                n_cmp++; if (o.wb_data !== addr || o.req_cnt !== 0) begin n_mis++; $display("FAIL rnd%0d_alu: got %h req=%0d want %h/0", i, o.wb_data, o.req_cnt, addr); end
            end else if (!mis) begin
                n_cmp++;
                if (o.req_cnt !== rdy || o.stable !== 1 || o.req_addr !== {addr[31:2], 2'b00} || o.we !== sto) begin
                    n_mis++; $display("FAIL rnd%0d_bus op=%0d: got cyc=%0d stable=%0d addr=%h we=%b want %0d/1/%h/%b",
                                      i, op, o.req_cnt, o.stable, o.req_addr, o.we, rdy, {addr[31:2], 2'b00}, sto);
                end
                if (sto) begin
                    n_cmp++; if (o.be !== m_be(op, longint'(addr)) || o.wdata !== m_wdata(op, longint'(st))) begin
                        n_mis++; $display("FAIL rnd%0d_store op=%0d: got be=%b wd=%h want %b/%h",
                                          i, op, o.be, o.wdata, m_be(op, longint'(addr)), m_wdata(op, longint'(st)));
                    end
                end else begin
                    n_cmp++; if (o.wb_data !== m_load(op, longint'(addr), longint'(rdata))) begin
                        n_mis++; $display("FAIL rnd%0d_load op=%0d addr=%h: got %h want %h",
                                          i, op, addr, o.wb_data, m_load(op, longint'(addr), longint'(rdata)));
                    end
                end
            end else begin
                n_cmp++; if (o.req_cnt !== 0) begin n_mis++; $display("FAIL rnd%0d_misalign_req: got %0d want 0", i, o.req_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_sw();
        test_load_byte();
        test_half();
        test_rd0();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access stage. Sits directly downstream of the EX/ME pipeline register and consumes its rd_we/rd_addr/rd_data outputs plus the memory-op fields.
- Performs loads and stores over a req/ready + rvalid data-memory bus.
- Registers the writeback result toward WB and stalls upstream while an access is outstanding.

Parameters:
- AW, 32, data-memory address width; rd_data_i[AW-1:0] is the effective address.
- DW, 32, data width; fixed at 32, only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid_i  in  1  upstream holds a valid instruction
- rd_we_i  in  1  register-write enable from EX/ME
- rd_addr_i  in  5  destination register
- rd_data_i  in  32  ALU result; this is the effective address for memory ops
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes are treated as NONE
- st_data_i  in  32  store data (rs2)
- stall_o  out  1  upstream must hold EX/ME contents this cycle
- dmem_req_o  out  1  bus request, registered
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  AW  word-aligned address ([1:0] = 0)
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_ready_i  in  1  bus accepts the request this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data word
- wb_valid_o  out  1  registered result valid for WB
- wb_rd_we_o  out  1  registered write enable
- wb_rd_addr_o  out  5  registered destination
- wb_rd_data_o  out  32  registered writeback data
- misalign_o  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. All outputs 0, including dmem_* outputs, wb_* outputs, misalign_o and stall_o.
- FSM states: IDLE, REQ, RESP.
- IDLE, in_valid_i=1, op NONE: next edge sets wb_valid=1 and passes rd_we/rd_addr/rd_data through. Latency 1.
- IDLE, in_valid_i=1, memory op:
  - Latch op, byte offset, rd_addr and store data.
  - Next edge: dmem_req_o=1 with addr/be/wdata, state REQ.
  - wb_valid=0 that cycle.
- REQ: hold every dmem_* output stable until dmem_ready_i=1. On that edge dmem_req_o falls.
  - Store: wb_valid=1 and wb_rd_we=0 on the same edge, then IDLE. Minimum latency 2.
  - Load: go to RESP.
- RESP: on dmem_rvalid_i=1, select the lane by offset and sign- or zero-extend, then wb_valid=1, wb_rd_we=rd_we, and go to IDLE. Minimum latency 3.
  - dmem_rvalid_i is ignored outside RESP.
- wb_valid_o is a single-cycle pulse per instruction. wb_rd_we_o is forced to 0 when rd_addr=0.
- stall_o is combinational: (state!=IDLE) OR (in_valid_i AND op!=NONE). Upstream input is sampled only in IDLE.
- Byte enables:
  - SB: 0001 shifted left by addr[1:0].
  - SH: 0011 shifted left by 2×addr[1].
  - SW: 1111.
- Write data: SB replicates the byte ×4; SH replicates the half ×2.
- Load selection: byte = rdata[8·off +: 8]; half = rdata[16·addr[1] +: 16].
- A dmem_ready_i that arrives in the same cycle as a new req assertion counts only from the first cycle req is high; there is no combinational ready→req path.
- Reset in REQ or RESP aborts the transaction: no wb pulse is produced, and a late rvalid after reset is ignored.

Optional Feature:
- Macro ME_MISALIGN_CHECK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - No bus request is issued.
  - Next edge: wb_valid=1, wb_rd_we=0, misalign_o=1 for 1 cycle, state stays IDLE.
- Undefined:
  - Offending low address bits are ignored: LH/SH use addr[1] only; LW/SW use offset 0.
  - misalign_o is tied 0.

Decomposition:
- Shared package me_pkg holds:
  - mem_op encoding localparams (OP_NONE..OP_SW),
  - FSM state encodings,
  - helper predicates is_load, is_store, access size.
- Sub-module me_load_align (combinational): offset + op + rdata → extended 32-bit data. The store lane/be logic stays inline.

Test Plan:
- ALU op, rd=5, data 0x1234, in_valid 1 → next cycle wb_valid=1, wb_rd_addr=5, wb_rd_data=0x1234, stall_o=0.
- SW addr 0x100, data 0xDEADBEEF, ready delayed 3 cycles → req held 3 cycles at addr 0x100, be=1111, stall_o high throughout; wb_valid with rd_we=0 on the ready edge.
- LB addr 0x103, rdata 0x80FF_0000 after 2 rvalid-wait cycles → wb_rd_data=0xFFFFFF80. The same access with LBU → 0x00000080.
- SH addr 0x102, data 0x0000ABCD → be=1100, wdata=0xABCDABCD; LH addr 0x102 with rdata 0x7FFF0000 → 0x00007FFF.
- LW to rd=0 → wb_valid=1, wb_rd_we=0.
- rst_n low mid-RESP, then rvalid arrives → all outputs 0, no wb pulse.
- With ME_MISALIGN_CHECK_EN, LW addr 0x101 → misalign_o 1 for 1 cycle, no dmem_req.
